// File: rtl/sqrt_iter_hs.sv
// sqrt_iter_hs: iterative restoring integer square root, floor(sqrt(A)),
// resolving UNROLL root bits per clock, with valid/ready handshakes on
// the operand and result sides.
// Optional feature macro: SQRT_REMAINDER_EN drives rem = A - root^2;
// without it rem is tied to zero (the internal remainder is still kept
// because every digit decision depends on it).
module sqrt_iter_hs #(
  parameter int N      = 8,
  parameter int UNROLL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N/2-1:0] root,
  output logic [N/2:0]   rem
);

  localparam int H  = N / 2;
  localparam int K  = N / (2 * UNROLL);
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N-1:0]  opnd;
  logic [H-1:0]  q;
  logic [H+1:0]  r;
  logic [CW-1:0] cnt;

  logic [N-1:0]  opnd_n;
  logic [H-1:0]  q_n;
  logic [H+1:0]  r_n;
  logic [H+1:0]  r_sh;
  logic [H+1:0]  t;

  // UNROLL restoring digit steps chained combinationally from the current registers
  always_comb begin
    opnd_n = opnd;
    q_n    = q;
    r_n    = r;
    r_sh   = '0;
    t      = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      r_sh   = {r_n[H-1:0], opnd_n[N-1:N-2]};
      opnd_n = {opnd_n[N-3:0], 2'b00};
      t      = {q_n, 2'b01};
      if (r_sh >= t) begin
        r_n = r_sh - t;
        q_n = {q_n[H-2:0], 1'b1};
      end else begin
        r_n = r_sh;
        q_n = {q_n[H-2:0], 1'b0};
      end
    end
  end

  // Handshake FSM with datapath registers and registered flow-control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      opnd      <= '0;
      q         <= '0;
      r         <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd     <= A;
            q        <= '0;
            r        <= '0;
            cnt      <= CW'(K);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          opnd <= opnd_n;
          q    <= q_n;
          r    <= r_n;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign root = q;

`ifdef SQRT_REMAINDER_EN
  // The final remainder never exceeds 2*root, so the top internal bit is always zero
  assign rem = r[H:0];
`else
  assign rem = '0;
`endif

endmodule

// File: tb/tb_sqrt_iter_hs.sv
// tb_sqrt_iter_hs: directed vectors for sqrt_iter_hs at N=8/UNROLL=1 and
// N=16/UNROLL=4, covering latency, boundaries, backpressure and reset abort.
module tb_sqrt_iter_hs;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8;
  logic [3:0] root8;
  logic [4:0] rem8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16;
  logic [7:0]  root16;
  logic [8:0]  rem16;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  sqrt_iter_hs #(.N(8), .UNROLL(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .A(a8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .root(root8), .rem(rem8)
  );

  sqrt_iter_hs #(.N(16), .UNROLL(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .A(a16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .root(root16), .rem(rem16)
  );

  function automatic int exp_rem(input int v);
`ifdef SQRT_REMAINDER_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out8(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid8 && n < 40);
  endtask

  task automatic wait_out16(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid16 && n < 40);
  endtask

  initial begin
    rst = 1'b0;
    in_valid8 = 1'b0;  a8 = '0;  out_ready8 = 1'b0;
    in_valid16 = 1'b0; a16 = '0; out_ready16 = 1'b0;
    step();
    step();

    check("rst_in_ready8",  32'(in_ready8),  1);
    check("rst_out_valid8", 32'(out_valid8), 0);
    check("rst_root8",      32'(root8),      0);
    check("rst_rem8",       32'(rem8),       0);
    check("rst_in_ready16", 32'(in_ready16), 1);
    check("rst_root16",     32'(root16),     0);
    rst = 1'b1;

    // A=144 with out_ready held high throughout
    a8 = 8'd144; in_valid8 = 1'b1; out_ready8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    check("t1_busy", 32'(in_ready8), 0);
    wait_out8(lat);
    check("t1_latency", lat, 4);
    check("t1_root", 32'(root8), 12);
    check("t1_rem",  32'(rem8), exp_rem(0));
    step();
    check("t1_out_valid_drop", 32'(out_valid8), 0);
    check("t1_in_ready_back",  32'(in_ready8), 1);

    // A=0 then A=255 back-to-back with in_valid held high
    a8 = 8'd0; in_valid8 = 1'b1;
    step();
    a8 = 8'd255;
    wait_out8(lat);
    check("t2a_latency", lat, 4);
    check("t2a_root", 32'(root8), 0);
    check("t2a_rem",  32'(rem8), 0);
    step();
    check("t2_idle_edge5", 32'(in_ready8), 1);
    step();
    check("t2_accept_edge6", 32'(in_ready8), 0);
    in_valid8 = 1'b0;
    a8 = 8'd3;
    wait_out8(lat);
    check("t2b_latency", lat, 4);
    check("t2b_root", 32'(root8), 15);
    check("t2b_rem",  32'(rem8), exp_rem(30));
    step();

    // N=16, UNROLL=4
    out_ready16 = 1'b1;
    a16 = 16'd65535; in_valid16 = 1'b1;
    step();
    in_valid16 = 1'b0;
    wait_out16(lat);
    check("t3a_latency", lat, 2);
    check("t3a_root", 32'(root16), 255);
    check("t3a_rem",  32'(rem16), exp_rem(510));
    step();
    a16 = 16'd1000; in_valid16 = 1'b1;
    step();
    in_valid16 = 1'b0;
    wait_out16(lat);
    check("t3b_latency", lat, 2);
    check("t3b_root", 32'(root16), 31);
    check("t3b_rem",  32'(rem16), exp_rem(39));
    step();

    // Backpressure: result held through 10 stalled cycles with in_valid noise
    out_ready8 = 1'b0;
    a8 = 8'd200; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    wait_out8(lat);
    check("t4_latency", lat, 4);
    check("t4_root", 32'(root8), 14);
    check("t4_rem",  32'(rem8), exp_rem(4));
    for (int i = 0; i < 10; i++) begin
      in_valid8 = (i % 2 == 1);
      a8 = 8'd5;
      step();
      check("t4_hold_valid", 32'(out_valid8), 1);
      check("t4_hold_root",  32'(root8), 14);
      check("t4_hold_rem",   32'(rem8), exp_rem(4));
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    step();
    check("t4_xfer_valid", 32'(out_valid8), 0);
    check("t4_xfer_ready", 32'(in_ready8), 1);
    step();
    check("t4_no_ghost_accept", 32'(in_ready8), 1);

    // Reset asserted after 2 compute edges aborts the computation
    a8 = 8'd99; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("t5_abort_valid", 32'(out_valid8), 0);
    check("t5_abort_ready", 32'(in_ready8), 1);
    check("t5_abort_root",  32'(root8), 0);
    step();
    rst = 1'b1;
    a8 = 8'd99; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    wait_out8(lat);
    check("t5_latency", lat, 4);
    check("t5_root", 32'(root8), 9);
    check("t5_rem",  32'(rem8), exp_rem(18));
    step();

    // A=50: remainder present only in the SQRT_REMAINDER_EN build
    a8 = 8'd50; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    wait_out8(lat);
    check("t6_latency", lat, 4);
    check("t6_root", 32'(root8), 7);
    check("t6_rem",  32'(rem8), exp_rem(1));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_iter_hs.md
# sqrt_iter_hs

Parametrised iterative integer square-root engine with valid/ready handshakes on both sides. It computes floor(sqrt(A)) and, optionally, the remainder A − root² using the restoring digit-by-digit method. It resolves UNROLL root bits per clock and accepts one operand per computation. It sits in the arithmetic library beside the combinational and sequential square-root blocks and replaces their start/ready control with flow-controlled streaming I/O.

## Interface
- N, default 8: operand width; even, ≥ 4.
- UNROLL, default 1: root bits resolved per clock; must divide N/2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand A is valid.
- in_ready  output  1  block can accept an operand.
- A  input  N  unsigned radicand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- root  output  N/2  floor(sqrt(A)).
- rem  output  N/2+1  A − root².

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, capture A into the shift register, clear the partial root and remainder, load step counter K=N/(2·UNROLL), and go to CALC.
  - CALC: in_ready=0, out_valid=0. Perform UNROLL digit steps per clock and decrement the counter. When the counter reaches 1, go to DONE on the same edge as the final step.
  - DONE: out_valid=1. root and rem stay stable until out_ready=1, then go to IDLE.
- Digit step, unrolled combinationally UNROLL times per clock:
  - r' = (r<<2) | top two bits of the operand shift register; shift the operand left by 2.
  - t = (q<<2) | 1.
  - If r' ≥ t: r = r' − t and q = (q<<1)|1. Otherwise r = r' and q = q<<1.
- Width rules:
  - The remainder register is N/2+2 bits wide internally. Its final value is always ≤ 2·root and fits in N/2+1 bits; rem is the low N/2+1 bits.
  - q is N/2 bits. No truncation error is permitted.
- Handshakes:
  - An input transfer is in_valid & in_ready at a rising edge.
  - An output transfer is out_valid & out_ready at a rising edge.
  - in_valid during CALC or DONE is ignored. A is sampled only on the accept edge, so A may change afterwards.
  - out_valid never drops without a transfer. root and rem do not change while out_valid=1.
- Boundaries:
  - A=0 gives root 0, rem 0.
  - A=2^N−1 gives root 2^(N/2)−1, rem 2^(N/2+1)−2.
  - Holding out_ready=1 in IDLE or CALC has no effect.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, root=0, rem=0, internal counter and registers=0.
- The first edge after rst deasserts may accept an operand.
- Latency: accept at edge E; out_valid rises after edge E+K, where K=N/(2·UNROLL).
- Minimum operand spacing is K+2 clocks: K compute edges, 1 DONE/handshake edge with out_ready held at 1, then 1 IDLE accept edge.
- Reset asserted mid-CALC or mid-DONE aborts immediately. The in-flight result is discarded and never presented.

## Configuration
- SQRT_REMAINDER_EN defined: the remainder register is kept and rem is driven as specified.
- SQRT_REMAINDER_EN undefined: rem is constant 0.
  - The comparison still uses an internal remainder, because it is needed for root.
  - The final remainder is not registered to the output.
  - root, timing and handshakes are identical in both builds.

## Test plan
- N=8, UNROLL=1, A=144, out_ready=1 → out_valid exactly 4 edges after accept; root=12, rem=0; in_ready returns 1 one edge after the output transfer.
- N=8, A=0 and A=255 back-to-back → root=0/rem=0, then root=15/rem=30; second accept occurs no earlier than 6 clocks after the first.
- N=16, UNROLL=4, A=65535 → root=255, rem=510 after 2 compute edges; A=1000 → root=31, rem=39.
- Backpressure: N=8, A=200, out_ready=0 for 10 cycles → out_valid held at 1 with root=14, rem=4 stable; in_valid pulses during the hold are ignored; transfer occurs on the first out_ready=1 edge.
- Reset mid-CALC: N=8, A=99, assert rst=0 after 2 compute edges → out_valid=0, in_ready=1, root=0 immediately; after release, A=99 → root=9, rem=18 with no stale output.
- Build without SQRT_REMAINDER_EN, N=8, A=50 → root=7, rem=0, latency 4.
